// File: rtl/amstrad_mem_arbiter.sv
// Arbitrates one 16-bit external RAM port between video word fetches, CPU byte
// cycles and loader byte writes; stalls the CPU via cpu_wait until its access lands.
module amstrad_mem_arbiter #(
  parameter logic [6:0] VID_BASE  = 7'h00,
  parameter int         LD_STARVE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_wait,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  output logic        vid_overrun,
  input  logic        ld_wr,
  input  logic [22:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_busy,
  output logic        ram_req,
  output logic        ram_we,
  output logic [1:0]  ram_be,
  output logic [21:0] ram_addr,
  output logic [15:0] ram_dout,
  input  logic [15:0] ram_din,
  input  logic        ram_ack
);

  localparam int SW = $clog2(LD_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(LD_STARVE);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {G_VID, G_CPU, G_LD} gnt_t;

  state_t        state, state_next;
  gnt_t          gnt;
  logic          vid_pend, vid_redo;
  logic [14:0]   vid_addr_q;
  logic          cpu_pend, cpu_served, cpu_we_q;
  logic [22:0]   cpu_addr_q;
  logic [7:0]    cpu_data_q;
  logic          ld_pend;
  logic [22:0]   ld_addr_q;
  logic [7:0]    ld_data_q;
  logic [SW-1:0] starve;

  logic          cpu_new, ld_new, v_any, c_any, l_any, c_we;
  logic [14:0]   v_addr;
  logic [22:0]   c_addr, l_addr;
  logic [7:0]    c_data, l_data;
  logic          go_vid, go_cpu, go_ld, ack_done;
  logic          vid_done, cpu_done, ld_done;

  assign cpu_wait = (cpu_rd | cpu_wr) & ~cpu_served;
  assign cpu_new  = cpu_wait & ~cpu_pend;
  assign ld_new   = ld_wr & ~ld_pend;
  assign ld_busy  = ld_pend;

  // A request arriving in an IDLE cycle is granted at the same edge that captures it.
  assign v_any  = vid_pend | vid_req;
  assign v_addr = vid_req ? vid_addr : vid_addr_q;
  assign c_any  = cpu_pend | cpu_new;
  assign c_addr = cpu_pend ? cpu_addr_q : cpu_addr;
  assign c_we   = cpu_pend ? cpu_we_q : cpu_wr;
  assign c_data = cpu_pend ? cpu_data_q : cpu_dout;
  assign l_any  = ld_pend | ld_new;
  assign l_addr = ld_pend ? ld_addr_q : ld_addr;
  assign l_data = ld_pend ? ld_data_q : ld_data;

  assign vid_done = ack_done & (gnt == G_VID);
  assign cpu_done = ack_done & (gnt == G_CPU);
  assign ld_done  = ack_done & (gnt == G_LD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (v_any | c_any | l_any) state_next = ACCESS;
      ACCESS:  if (ram_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Video always first; a starved loader overtakes the CPU.
  always_comb begin
    go_vid   = 1'b0;
    go_cpu   = 1'b0;
    go_ld    = 1'b0;
    ack_done = 1'b0;
    case (state)
      IDLE: begin
        if (v_any)                             go_vid = 1'b1;
        else if (l_any && starve == STARVE_MAX) go_ld  = 1'b1;
        else if (c_any)                        go_cpu = 1'b1;
        else if (l_any)                        go_ld  = 1'b1;
      end
      ACCESS:  ack_done = ram_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt         <= G_VID;
      vid_pend    <= 1'b0;
      vid_redo    <= 1'b0;
      vid_addr_q  <= '0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      vid_overrun <= 1'b0;
      cpu_pend    <= 1'b0;
      cpu_served  <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_data_q  <= '0;
      cpu_din     <= 8'hFF;
      ld_pend     <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      starve      <= '0;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_be      <= '0;
      ram_addr    <= '0;
      ram_dout    <= '0;
    end else begin
      vid_valid   <= vid_done;
      vid_overrun <= vid_req & vid_pend & ~vid_done;
      if (vid_req) vid_addr_q <= vid_addr;
      // A fresh request during the in-flight fetch must survive that fetch's completion.
      vid_redo <= ~vid_done & (vid_redo | (vid_req & (state == ACCESS) & (gnt == G_VID)));
      vid_pend <= vid_req | (vid_pend & ~(vid_done & ~vid_redo));
      if (vid_done) vid_data <= ram_din;

      if (cpu_new) begin
        cpu_addr_q <= cpu_addr;
        cpu_we_q   <= cpu_wr;
        cpu_data_q <= cpu_dout;
      end
      cpu_pend   <= (cpu_pend | cpu_new) & ~cpu_done;
      cpu_served <= (cpu_served | cpu_done) & (cpu_rd | cpu_wr);
      if (cpu_done && !cpu_we_q) cpu_din <= cpu_addr_q[0] ? ram_din[15:8] : ram_din[7:0];

      if (ld_new) begin
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
      end
      ld_pend <= (ld_pend | ld_new) & ~ld_done;

      if (go_ld || !l_any) starve <= '0;
      else if (go_cpu)     starve <= starve + 1'b1;

      if (go_vid) begin
        gnt      <= G_VID;
        ram_req  <= 1'b1;
        ram_we   <= 1'b0;
        ram_be   <= 2'b11;
        ram_addr <= {VID_BASE, v_addr};
      end else if (go_cpu) begin
        gnt      <= G_CPU;
        ram_req  <= 1'b1;
        ram_we   <= c_we;
        ram_be   <= c_addr[0] ? 2'b10 : 2'b01;
        ram_addr <= c_addr[22:1];
        ram_dout <= {c_data, c_data};
      end else if (go_ld) begin
        gnt      <= G_LD;
        ram_req  <= 1'b1;
        ram_we   <= 1'b1;
        ram_be   <= l_addr[0] ? 2'b10 : 2'b01;
        ram_addr <= l_addr[22:1];
        ram_dout <= {l_data, l_data};
      end else if (ack_done) begin
        ram_req <= 1'b0;
        ram_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Directed bench for amstrad_mem_arbiter: a RAM responder pops expected accesses
// from a scoreboard queue and supplies read data; results are checked on output.
module tb_amstrad_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_wait;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_valid, vid_overrun;
  logic        ld_wr;
  logic [22:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_busy;
  logic        ram_req, ram_we;
  logic [1:0]  ram_be;
  logic [21:0] ram_addr;
  logic [15:0] ram_dout, ram_din;
  logic        ram_ack;

  amstrad_mem_arbiter #(.VID_BASE(7'h05), .LD_STARVE(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_wait(cpu_wait),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
    .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_din(ram_din), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } acc_t;

  acc_t        exp_acc[$];
  logic [15:0] exp_vid[$];
  int vectors = 0, miscompares = 0;
  int ack_delay = 0, acc_cnt = 0, vid_cnt = 0, ovr_cnt = 0;
  int cyc = 0, vid_ack_cyc = -10;
  bit drop_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic we, input logic [1:0] be, input logic [21:0] addr,
                          input logic [15:0] wd, input logic [15:0] rd);
    acc_t a;
    a.we = we; a.be = be; a.addr = addr; a.wdata = wd; a.rdata = rd;
    exp_acc.push_back(a);
  endtask

  task automatic wait_cpu_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cpu_wait) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_gnt(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ram_req && ram_be != 2'b11) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_vid(input string tag, input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (vid_cnt >= target) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // RAM responder: acks ack_delay cycles after ram_req rises, checks the access.
  initial begin
    acc_t a;
    int   wait_cnt;
    wait_cnt = 0;
    ram_ack  = 1'b0;
    ram_din  = '0;
    forever begin
      @(negedge clk);
      if (drop_chk) begin
        check("req_gap", 32'(ram_req), 32'd0);
        drop_chk = 1'b0;
      end
      if (ram_ack) begin
        ram_ack = 1'b0;
      end else if (ram_req) begin
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          if (exp_acc.size() == 0) begin
            check("unexpected_access", 32'(ram_addr), 32'hFFFF_FFFF);
          end else begin
            a = exp_acc.pop_front();
            check("acc_addr", 32'(ram_addr), 32'(a.addr));
            check("acc_be", 32'(ram_be), 32'(a.be));
            check("acc_we", 32'(ram_we), 32'(a.we));
            if (a.we) check("acc_wdata", 32'(ram_dout), 32'(a.wdata));
            ram_din = a.rdata;
          end
          if (ram_be == 2'b11 && !ram_we) vid_ack_cyc = cyc;
          ram_ack  = 1'b1;
          acc_cnt++;
          drop_chk = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Video result monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (vid_valid) begin
        check("vid_valid_latency", 32'(cyc), 32'(vid_ack_cyc + 1));
        if (exp_vid.size() == 0) check("unexpected_vid", 32'(vid_data), 32'hFFFF_FFFF);
        else                     check("vid_data", 32'(vid_data), 32'(exp_vid.pop_front()));
        vid_cnt++;
      end
      if (vid_overrun) ovr_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, v0, a0, o0;
    logic [7:0] dexp;
    reset = 1'b1;
    cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_dout = '0;
    vid_req = 1'b0; vid_addr = '0;
    ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_cpu_din", 32'(cpu_din), 32'hFF);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_be", 32'(ram_be), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_vid_data", 32'(vid_data), 32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_ld_busy", 32'(ld_busy), 32'd0);

    // Single CPU read, odd byte, ack 3 cycles after ram_req
    to_edge();
    ack_delay = 3;
    push_acc(1'b0, 2'b10, 22'h000002, 16'h0000, 16'hAB12);
    cpu_addr = 23'h000005; cpu_rd = 1'b1;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_wait) hi++;
      else break;
    end
    check("t1_wait_cycles", 32'(hi), 32'd5);
    check("t1_cpu_din", 32'(cpu_din), 32'hAB);
    to_edge();
    cpu_rd = 1'b0;
    to_edge();

    // Video and CPU write in the same cycle: video first
    ack_delay = 2;
    v0 = vid_cnt;
    push_acc(1'b0, 2'b11, {7'h05, 15'h1234}, 16'h0000, 16'h5A5A);
    exp_vid.push_back(16'h5A5A);
    push_acc(1'b1, 2'b01, 22'h000080, 16'h3C3C, 16'h0000);
    vid_req = 1'b1; vid_addr = 15'h1234;
    cpu_wr = 1'b1; cpu_addr = 23'h000100; cpu_dout = 8'h3C;
    to_edge();
    vid_req = 1'b0;
    wait_cpu_done("t2_cpu");
    check("t2_vid_count", 32'(vid_cnt - v0), 32'd1);
    check("t2_cpu_din_kept", 32'(cpu_din), 32'hAB);
    to_edge();
    cpu_wr = 1'b0;
    to_edge();
    check("t2_drained", 32'(exp_acc.size()), 32'd0);

    // Loader pending while the CPU keeps re-requesting behind video fetches
    ack_delay = 4;
    for (int k = 0; k < 8; k++) begin
      push_acc(1'b0, (k % 2) ? 2'b10 : 2'b01, 22'(22'h000200 + k / 2), 16'h0000,
               {8'(8'hC0 + k), 8'(8'h30 + k)});
      push_acc(1'b0, 2'b11, {7'h05, 15'(15'h0100 + k)}, 16'h0000, 16'(16'hE000 + k));
      exp_vid.push_back(16'(16'hE000 + k));
    end
    push_acc(1'b1, 2'b10, 22'h000180, 16'h7777, 16'h0000);
    push_acc(1'b0, 2'b11, {7'h05, 15'h0108}, 16'h0000, 16'hE008);
    exp_vid.push_back(16'hE008);
    push_acc(1'b0, 2'b01, 22'h000204, 16'h0000, 16'hC838);
    ld_wr = 1'b1; ld_addr = 23'h000301; ld_data = 8'h77;
    cpu_rd = 1'b1; cpu_addr = 23'h000400;
    to_edge();
    ld_wr = 1'b0;
    check("t3_ld_busy_set", 32'(ld_busy), 32'd1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        cpu_addr = 23'(23'h000400 + k);
        cpu_rd = 1'b1;
      end
      wait_gnt("t3_gnt");
      if (k == 8) check("t3_ld_busy_in_access", 32'(ld_busy), 32'd1);
      to_edge();
      vid_req = 1'b1; vid_addr = 15'(15'h0100 + k);
      if (k == 1) begin
        ld_wr = 1'b1; ld_addr = 23'h000002; ld_data = 8'h99;
      end
      to_edge();
      vid_req = 1'b0; ld_wr = 1'b0;
      wait_cpu_done("t3_cpu");
      dexp = (k % 2) ? 8'(8'hC0 + k) : 8'(8'h30 + k);
      check("t3_cpu_din", 32'(cpu_din), 32'(dexp));
      to_edge();
      cpu_rd = 1'b0;
      to_edge();
    end
    wait_vid("t3_vid", v0 + 10);
    check("t3_ld_busy_clear", 32'(ld_busy), 32'd0);
    check("t3_drained", 32'(exp_acc.size()), 32'd0);

    // Two video requests while a CPU access is stalled: one overrun, second fetched
    ack_delay = 8;
    o0 = ovr_cnt;
    v0 = vid_cnt;
    push_acc(1'b0, 2'b01, 22'h000008, 16'h0000, 16'h4455);
    push_acc(1'b0, 2'b11, {7'h05, 15'h0BBB}, 16'h0000, 16'hBEEF);
    exp_vid.push_back(16'hBEEF);
    cpu_rd = 1'b1; cpu_addr = 23'h000010;
    wait_gnt("t4_gnt");
    to_edge();
    vid_req = 1'b1; vid_addr = 15'h0AAA;
    to_edge();
    vid_req = 1'b0;
    to_edge();
    vid_req = 1'b1; vid_addr = 15'h0BBB;
    to_edge();
    vid_req = 1'b0;
    wait_cpu_done("t4_cpu");
    check("t4_cpu_din", 32'(cpu_din), 32'h55);
    wait_vid("t4_vid", v0 + 1);
    check("t4_overrun", 32'(ovr_cnt - o0), 32'd1);
    to_edge();
    cpu_rd = 1'b0;
    to_edge();

    // CPU holds rd long after completion: exactly one access per bus cycle
    ack_delay = 1;
    a0 = acc_cnt;
    push_acc(1'b0, 2'b10, 22'h000010, 16'h0000, 16'h9A00);
    cpu_rd = 1'b1; cpu_addr = 23'h000021;
    wait_cpu_done("t5_first");
    repeat (20) @(negedge clk);
    check("t5_one_access", 32'(acc_cnt - a0), 32'd1);
    check("t5_wait_low", 32'(cpu_wait), 32'd0);
    check("t5_cpu_din", 32'(cpu_din), 32'h9A);
    to_edge();
    cpu_rd = 1'b0;
    to_edge();
    push_acc(1'b0, 2'b01, 22'h000011, 16'h0000, 16'h00C3);
    cpu_rd = 1'b1; cpu_addr = 23'h000022;
    wait_cpu_done("t5_second");
    check("t5_two_access", 32'(acc_cnt - a0), 32'd2);
    check("t5_cpu_din2", 32'(cpu_din), 32'hC3);
    to_edge();
    cpu_rd = 1'b0;
    to_edge();

    // Reset during an access
    ack_delay = 10;
    push_acc(1'b0, 2'b01, 22'h000020, 16'h0000, 16'h1111);
    cpu_rd = 1'b1; cpu_addr = 23'h000040;
    wait_gnt("t6_gnt");
    to_edge();
    #2 reset = 1'b1;
    #1;
    check("t6_async_ram_req", 32'(ram_req), 32'd0);
    check("t6_async_cpu_din", 32'(cpu_din), 32'hFF);
    check("t6_async_vid_data", 32'(vid_data), 32'd0);
    cpu_rd = 1'b0;
    exp_acc.delete(0);
    to_edge();
    to_edge();
    reset = 1'b0;
    to_edge();
    ack_delay = 0;
    v0 = vid_cnt;
    push_acc(1'b0, 2'b10, 22'h000020, 16'h0000, 16'h6600);
    cpu_rd = 1'b1; cpu_addr = 23'h000041;
    wait_cpu_done("t6_cpu");
    check("t6_cpu_din", 32'(cpu_din), 32'h66);
    to_edge();
    cpu_rd = 1'b0;
    push_acc(1'b0, 2'b11, {7'h05, 15'h0007}, 16'h0000, 16'h1357);
    exp_vid.push_back(16'h1357);
    vid_req = 1'b1; vid_addr = 15'h0007;
    to_edge();
    vid_req = 1'b0;
    wait_vid("t6_vid", v0 + 1);
    repeat (3) @(negedge clk);

    check("final_overrun_total", 32'(ovr_cnt), 32'd1);
    check("final_acc_drained", 32'(exp_acc.size()), 32'd0);
    check("final_vid_drained", 32'(exp_vid.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
